// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters with a per-operation hold window
module alu_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int OPRN_WIDTH = 6,
  parameter int MUL_CYCLES = 4,
  parameter int MUL_CODE   = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0,
  input  logic                  REQ1,
  input  logic [DATA_WIDTH-1:0] OP1_0,
  input  logic [DATA_WIDTH-1:0] OP2_0,
  input  logic [DATA_WIDTH-1:0] OP1_1,
  input  logic [DATA_WIDTH-1:0] OP2_1,
  input  logic [OPRN_WIDTH-1:0] OPRN_0,
  input  logic [OPRN_WIDTH-1:0] OPRN_1,
  output logic                  DONE0,
  output logic                  DONE1,
  output logic [DATA_WIDTH-1:0] RESULT,
  output logic                  RES_ZERO,
  output logic                  BUSY,
  output logic                  GRANT_ID,
  output logic [DATA_WIDTH-1:0] ALU_OP1,
  output logic [DATA_WIDTH-1:0] ALU_OP2,
  output logic [OPRN_WIDTH-1:0] ALU_OPRN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  input  logic                  ALU_ZERO
);
  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_DONE} state_t;
  localparam logic [3:0] MUL_LAST = 4'(MUL_CYCLES - 1);
  localparam logic [OPRN_WIDTH-1:0] MUL_OP = OPRN_WIDTH'(MUL_CODE);
  state_t state_q, state_d;
  logic prio_q, prio_d, gid_q, gid_d, zero_q, zero_d, gnt;
  logic [3:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] op1_q, op1_d, op2_q, op2_d, res_q, res_d;
  logic [OPRN_WIDTH-1:0] oprn_q, oprn_d, oprn_n;
  assign gnt = (REQ0 && REQ1) ? prio_q : REQ1;
  assign oprn_n = gnt ? OPRN_1 : OPRN_0;
  always_comb begin
    state_d = state_q;
    prio_d = prio_q;
    gid_d = gid_q;
    cnt_d = cnt_q;
    op1_d = op1_q;
    op2_d = op2_q;
    oprn_d = oprn_q;
    res_d = res_q;
    zero_d = zero_q;
    case (state_q)
      S_IDLE: if (REQ0 || REQ1) begin
        state_d = S_EXEC;
        gid_d = gnt;
        prio_d = ~gnt;
        op1_d = gnt ? OP1_1 : OP1_0;
        op2_d = gnt ? OP2_1 : OP2_0;
        oprn_d = oprn_n;
        cnt_d = (oprn_n == MUL_OP) ? MUL_LAST : 4'd0;
      end
      S_EXEC: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        state_d = S_DONE;
        res_d = ALU_OUT;
        zero_d = ALU_ZERO;
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      prio_q <= 1'b0;
      gid_q <= 1'b0;
      cnt_q <= 4'd0;
      op1_q <= '0;
      op2_q <= '0;
      oprn_q <= '0;
      res_q <= '0;
      zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      prio_q <= prio_d;
      gid_q <= gid_d;
      cnt_q <= cnt_d;
      op1_q <= op1_d;
      op2_q <= op2_d;
      oprn_q <= oprn_d;
      res_q <= res_d;
      zero_q <= zero_d;
    end
  end
  assign BUSY = state_q != S_IDLE;
  assign DONE0 = (state_q == S_DONE) && !gid_q;
  assign DONE1 = (state_q == S_DONE) && gid_q;
  assign GRANT_ID = gid_q;
  assign RESULT = res_q;
  assign RES_ZERO = zero_q;
  assign ALU_OP1 = op1_q;
  assign ALU_OP2 = op2_q;
  assign ALU_OPRN = oprn_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: scoreboard bench for alu_arbiter with a cycle-level transaction model
module tb_alu_arbiter;
  localparam int MULC = 4;
  typedef struct { logic id; logic [31:0] res; logic z; int at; } exp_t;
  logic CLK = 1'b0, RST = 1'b1;
  logic req [2];
  logic [31:0] op1 [2], op2 [2];
  logic [5:0] opc [2];
  logic DONE0, DONE1, RES_ZERO, BUSY, GRANT_ID, alu_zero;
  logic [31:0] RESULT, ALU_OP1, ALU_OP2, alu_out;
  logic [5:0] ALU_OPRN;
  exp_t q [$];
  int hold [2];
  int cyc = 0, total = 0, bad = 0;
  int free_at = 0, rst_edge = -1, cur_t0 = -1000, cur_l = 0;
  logic prio = 1'b0, cur_id = 1'b0;
  logic [31:0] cur_a = '0, cur_b = '0;
  logic [5:0] cur_c = '0;
  logic [5:0] codes [6] = '{6'd0, 6'd1, 6'd2, 6'd3, 6'd5, 6'd63};
  alu_arbiter #(.DATA_WIDTH(32), .OPRN_WIDTH(6), .MUL_CYCLES(MULC), .MUL_CODE(3)) dut (
    .CLK(CLK), .RST(RST), .REQ0(req[0]), .REQ1(req[1]),
    .OP1_0(op1[0]), .OP2_0(op2[0]), .OP1_1(op1[1]), .OP2_1(op2[1]),
    .OPRN_0(opc[0]), .OPRN_1(opc[1]), .DONE0(DONE0), .DONE1(DONE1),
    .RESULT(RESULT), .RES_ZERO(RES_ZERO), .BUSY(BUSY), .GRANT_ID(GRANT_ID),
    .ALU_OP1(ALU_OP1), .ALU_OP2(ALU_OP2), .ALU_OPRN(ALU_OPRN),
    .ALU_OUT(alu_out), .ALU_ZERO(alu_zero)
  );
  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;
  function automatic logic [31:0] ref_alu(logic [31:0] a, logic [31:0] b, logic [5:0] c);
    return c == 6'd0 ? a + b : c == 6'd1 ? a - b : c == 6'd2 ? a & b : c == 6'd3 ? a * b : a;
  endfunction
  always_comb begin
    alu_out = ref_alu(ALU_OP1, ALU_OP2, ALU_OPRN);
    alu_zero = alu_out == 32'd0;
  end
  task automatic chk(string nm, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h cycle=%0d", nm, act, exp, cyc);
    end
  endtask
  task automatic predict(int e);
    int n, l;
    if (RST) begin
      q.delete();
      prio = 1'b0;
      free_at = e + 1;
      cur_t0 = -1000;
      rst_edge = e;
    end else if (e >= free_at && (req[0] || req[1])) begin
      n = (req[0] && req[1]) ? int'(prio) : (req[1] ? 1 : 0);
      l = opc[n] == 6'd3 ? MULC : 1;
      cur_id = n[0];
      cur_a = op1[n];
      cur_b = op2[n];
      cur_c = opc[n];
      cur_t0 = e;
      cur_l = l;
      q.push_back('{id: n[0], res: ref_alu(op1[n], op2[n], opc[n]),
                    z: ref_alu(op1[n], op2[n], opc[n]) == 32'd0, at: e + l});
      free_at = e + l + 2;
      prio = ~n[0];
    end
  endtask
  task automatic tick();
    predict(cyc + 1);
    @(negedge CLK);
    #1;
    for (int n = 0; n < 2; n++)
      if (req[n] && (n == 1 ? DONE1 : DONE0)) begin
        if (hold[n] > 0) hold[n]--;
        else req[n] = 1'b0;
      end
  endtask
  task automatic issue(int n, logic [31:0] a, logic [31:0] b, logic [5:0] c, int h);
    req[n] = 1'b1;
    op1[n] = a;
    op2[n] = b;
    opc[n] = c;
    hold[n] = h;
  endtask
  task automatic wait_idle();
    int i = 0;
    while (i < 80 && !(q.size() == 0 && cyc + 1 >= free_at && !req[0] && !req[1])) begin
      tick();
      i++;
    end
    if (i >= 80) begin
      total++;
      bad++;
      $display("FAIL wait_idle timeout pending=%0d cycle=%0d", q.size(), cyc);
    end
  endtask
  always @(negedge CLK) begin
    automatic int k = cyc;
    automatic logic busy_exp = k >= cur_t0 && k <= cur_t0 + cur_l;
    exp_t e;
    if (k == rst_edge)
      chk("reset_outputs", {DONE0, DONE1, BUSY, GRANT_ID, RES_ZERO, RESULT, ALU_OP1, ALU_OP2, ALU_OPRN}, '0);
    chk("busy", BUSY, busy_exp);
    if (busy_exp)
      chk("alu_inputs", {ALU_OP1, ALU_OP2, ALU_OPRN, GRANT_ID}, {cur_a, cur_b, cur_c, cur_id});
    if (DONE0 || DONE1) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_done done0=%b done1=%b want none cycle=%0d", DONE0, DONE1, k);
      end else begin
        e = q.pop_front();
        chk("done_id", {DONE1, DONE0}, e.id ? 2'b10 : 2'b01);
        chk("result", RESULT, e.res);
        chk("res_zero", RES_ZERO, e.z);
        chk("done_cycle", k, e.at);
      end
    end else if (q.size() > 0 && k > q[0].at) begin
      total++;
      bad++;
      $display("FAIL done_missing got=none want_cycle=%0d cycle=%0d", q[0].at, k);
      void'(q.pop_front());
    end
  end
  initial begin
    for (int n = 0; n < 2; n++) begin
      req[n] = 1'b0;
      op1[n] = '0;
      op2[n] = '0;
      opc[n] = '0;
      hold[n] = 0;
    end
    tick();
    tick();
    RST = 1'b0;
    tick();
    issue(0, 32'd5, 32'd7, 6'd0, 0);
    wait_idle();
    issue(1, 32'h1234, 32'h1234, 6'd1, 0);
    wait_idle();
    issue(0, 32'h10000, 32'd3, 6'd3, 0);
    wait_idle();
    RST = 1'b1;
    tick();
    RST = 1'b0;
    issue(0, 32'h10000, 32'd3, 6'd3, 1);
    issue(1, 32'h1234, 32'h1234, 6'd1, 0);
    tick();
    op1[1] = 32'd20;
    op2[1] = 32'd8;
    wait_idle();
    issue(0, 32'h10000, 32'd5, 6'd3, 0);
    tick();
    tick();
    RST = 1'b1;
    req[0] = 1'b0;
    tick();
    RST = 1'b0;
    issue(0, 32'd9, 32'd1, 6'd1, 0);
    issue(1, 32'd3, 32'd4, 6'd0, 0);
    wait_idle();
    for (int t = 0; t < 400; t++) begin
      for (int n = 0; n < 2; n++)
        if (!req[n] && $urandom_range(0, 2) == 0) begin
          automatic logic [31:0] a = $urandom;
          issue(n, a, $urandom_range(0, 3) == 0 ? a : $urandom,
                codes[$urandom_range(0, 5)], $urandom_range(0, 3) == 0 ? 1 : 0);
        end
      tick();
    end
    wait_idle();
    tick();
    tick();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port arbiter and sequencer that shares the single combinational ALU between two requesters, e.g. the execute path and the address/branch-compare path. It registers the winning requester's operands and operation code onto the ALU inputs and holds them for a fixed per-operation latency. Multiply gets a longer window so the deep multiplier array can settle. It then captures the ALU result and zero flag and returns them with a one-cycle done pulse to the granted requester.

## Interface
- DATA_WIDTH, 32, operand/result width (matches ALU data width)
- OPRN_WIDTH, 6, ALU operation-code width
- MUL_CYCLES, 4, ALU-hold cycles for the multiply code (legal range 1..15)
- MUL_CODE, 3, operation code that selects the multiply latency
- CLK  input  1  clock; all state changes on rising edge
- RST  input  1  synchronous, active-high reset
- REQ0 / REQ1  input  1  request from requester 0 / 1
- OP1_0, OP2_0 / OP1_1, OP2_1  input  DATA_WIDTH  operands of requester 0 / 1
- OPRN_0 / OPRN_1  input  OPRN_WIDTH  operation code of requester 0 / 1
- DONE0 / DONE1  output  1  one-cycle completion pulse to requester 0 / 1
- RESULT  output  DATA_WIDTH  captured ALU result of last completed operation
- RES_ZERO  output  1  captured ALU zero flag of last completed operation
- BUSY  output  1  high while state is not IDLE
- GRANT_ID  output  1  requester owning the current or last transaction
- ALU_OP1, ALU_OP2  output  DATA_WIDTH  registered operands driven to the ALU
- ALU_OPRN  output  OPRN_WIDTH  registered operation code driven to the ALU
- ALU_OUT  input  DATA_WIDTH  ALU result
- ALU_ZERO  input  1  ALU zero flag

## Operation
- States: IDLE, EXEC, DONE. Reset value is IDLE.
- Priority pointer PRIO is 1 bit and resets to 0.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one REQn high: grant n.
  - Both high: grant PRIO.
  - On grant: latch OP1_n/OP2_n/OPRN_n into ALU_OP1/ALU_OP2/ALU_OPRN, set GRANT_ID=n, set PRIO=~n, load counter CNT=L-1, go to EXEC.
- L (hold cycles): MUL_CYCLES when OPRN_n==MUL_CODE, otherwise 1. Every other code, including codes the ALU does not implement, uses L=1 and passes through unchanged.
- EXEC:
  - ALU_* registers are held constant.
  - CNT>0: decrement CNT.
  - CNT==0: capture RESULT<=ALU_OUT and RES_ZERO<=ALU_ZERO, then go to DONE.
- DONE: assert DONE[GRANT_ID] for exactly this cycle, then go to IDLE unconditionally. The arbiter never grants directly from DONE.
- Requester rules:
  - Hold REQn and its operands stable from assertion until its DONEn pulse.
  - Deassert REQn at the edge ending the DONEn cycle.
  - REQn still high one cycle after DONEn is taken as a new transaction.
- Request changes while not IDLE are ignored. The latched ALU inputs make later operand changes harmless.
- ALU_* hold their last values in IDLE and DONE. RESULT/RES_ZERO hold until the next capture.
- Fairness: with both requesters continuously requesting, grants strictly alternate 0,1,0,1,...
- Reset mid-operation:
  - State goes to IDLE, PRIO=0.
  - No DONE pulse is issued for the aborted transaction.
  - All outputs take their reset values.
- Output reset values: DONE0=DONE1=0, BUSY=0, GRANT_ID=0, RESULT=0, RES_ZERO=0, ALU_OP1=ALU_OP2=0, ALU_OPRN=0.

## Timing
- Edge t0: request sampled in IDLE; ALU inputs valid during cycle t0..t0+1.
- Capture edge: t0+L.
- DONEn high: cycle t0+L to t0+L+1.
- IDLE reached: edge t0+L+1. Next grant possible at edge t0+L+2.
- Request-to-DONE latency is L cycles. Throughput is one transaction per L+2 cycles.
- BUSY is high from edge t0 to edge t0+L+1; it is registered and derived from state.
- DONEn, RESULT and RES_ZERO are registered. RESULT and RES_ZERO are stable during the DONEn cycle.
- No combinational path from REQn or OPn to any output.

## Test plan
- Single ADD, requester 0: OP1_0=5, OP2_0=7, add code; REQ0 sampled at t0 -> ALU_OP1=5 from t0, DONE0 in cycle t0+1, RESULT=12, RES_ZERO=0, GRANT_ID=0, DONE1 stays 0.
- SUB of equal operands, requester 1: OP1_1=OP2_1=0x1234 -> RESULT=0, RES_ZERO=1, DONE1 single pulse.
- MUL, MUL_CYCLES=4: 0x10000 x 3 -> ALU inputs stable for 4 cycles, DONE0 in cycle t0+4, RESULT=0x30000, BUSY high for exactly 5 cycles.
- Simultaneous REQ0=REQ1=1 from reset: grants go 0 then 1 then 0 (DONE0, DONE1, DONE0); each RESULT matches its own operands; stale operand changes on the waiting port during EXEC do not affect the running result.
- Reset mid-MUL: assert RST for 1 cycle during EXEC with CNT=2 -> no DONE pulse, all outputs 0, BUSY=0. Next simultaneous request grants requester 0.
- Held REQ0 after DONE0: keep REQ0 high one extra cycle -> second transaction on requester 0. With REQ1 pending, requester 1 is served first (PRIO=1).
